// File: rtl/dbg_ctrl_pkg.sv
// Shared types for the debug controller: op codes, FSM encoding, bus payloads.
package dbg_ctrl_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [OP_W-1:0] {
    DBG_NOP    = 3'd0,
    DBG_HALT   = 3'd1,
    DBG_RESUME = 3'd2,
    DBG_RESET  = 3'd3,
    DBG_REG_RD = 3'd4,
    DBG_REG_WR = 3'd5
  } dbg_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_RST    = 3'd2,
    ST_ACCESS = 3'd3,
    ST_RESP   = 3'd4
  } dbg_state_e;

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } gpr_req_t;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } dbg_resp_t;

  // Counter preload for an N-cycle wait: exits when the count reaches 0.
  function automatic logic [CNT_W-1:0] cnt_preload(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/dbg_cnt.sv
// Loadable down-counter with zero flag; saturates at 0 instead of wrapping.
module dbg_cnt
  import dbg_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/dbg_ctrl.sv
// Debug controller: accepts one debug command at a time and drives the core's
// halt/reset/GPR debug ports, returning a single response per command.
module dbg_ctrl
  import dbg_ctrl_pkg::*;
#(
  parameter int unsigned HALT_SETTLE  = 2,
  parameter int unsigned RESET_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              halted,
  output logic              jtag_halt,
  output logic              jtag_reset,
  output logic              reg_wen,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_w_data,
  input  logic [DATA_W-1:0] reg_r_data
);

  dbg_state_e       state_q, state_d;
  logic             halt_q, halt_d;
  logic             halted_q, halted_d;
  logic             jreset_q, jreset_d;
  gpr_req_t         req_q, req_d;
  dbg_resp_t        resp_q, resp_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero_c;

  dbg_cnt u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero_c   (cnt_zero_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      halt_q   <= 1'b0;
      halted_q <= 1'b0;
      jreset_q <= 1'b0;
      req_q    <= '0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      halt_q   <= halt_d;
      halted_q <= halted_d;
      jreset_q <= jreset_d;
      req_q    <= req_d;
      resp_q   <= resp_d;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d  = state_q;
    halt_d   = halt_q;
    halted_d = halted_q;
    jreset_d = 1'b0;
    req_d    = '0;
    resp_d   = resp_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          resp_d  = '0;
          state_d = ST_RESP;
          case (dbg_op_e'(cmd_op))
            DBG_NOP: ;
            DBG_HALT: begin
              if (!halted_q) begin
                halt_d   = 1'b1;
                state_d  = ST_SETTLE;
                cnt_load = 1'b1;
                cnt_val  = cnt_preload(HALT_SETTLE);
              end
            end
            DBG_RESUME: begin
              halt_d   = 1'b0;
              halted_d = 1'b0;
            end
            DBG_RESET: begin
              jreset_d = 1'b1;
              state_d  = ST_RST;
              cnt_load = 1'b1;
              cnt_val  = cnt_preload(RESET_CYCLES);
            end
            DBG_REG_RD, DBG_REG_WR: begin
              if (halted_q) begin
                state_d    = ST_ACCESS;
                req_d.wen  = (dbg_op_e'(cmd_op) == DBG_REG_WR);
                req_d.addr = cmd_addr;
                if (dbg_op_e'(cmd_op) == DBG_REG_WR) begin
                  req_d.wdata = cmd_data;
                end
              end else begin
                resp_d.err = 1'b1;
              end
            end
            default: resp_d.err = 1'b1;
          endcase
        end
      end

      ST_SETTLE: begin
        if (cnt_zero_c) begin
          halted_d = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_RST: begin
        if (cnt_zero_c) begin
          state_d = ST_RESP;
        end else begin
          jreset_d = 1'b1;
          cnt_dec  = 1'b1;
        end
      end

      // Read data is sampled at the end of the single access cycle.
      ST_ACCESS: begin
        resp_d.err  = 1'b0;
        resp_d.data = req_q.wen ? '0 : reg_r_data;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        if (resp_ready) begin
          resp_d  = '0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_data  = resp_q.data;
  assign resp_err   = resp_q.err;
  assign halted     = halted_q;
  assign jtag_halt  = halt_q;
  assign jtag_reset = jreset_q;
  assign reg_wen    = req_q.wen;
  assign reg_addr   = req_q.addr;
  assign reg_w_data = req_q.wdata;

endmodule

// File: tb/tb_dbg_ctrl.sv
// Directed and random command bench for dbg_ctrl with a behavioural core/GPR model.
module tb_dbg_ctrl;

  localparam int unsigned HS = 2;
  localparam int unsigned RC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [4:0]  cmd_addr = 5'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        halted;
  logic        jtag_halt;
  logic        jtag_reset;
  logic        reg_wen;
  logic [4:0]  reg_addr;
  logic [31:0] reg_w_data;
  logic [31:0] reg_r_data;

  int n_assert = 0;
  int n_fail   = 0;

  // Core GPR file and write-enable monitor.
  logic [31:0] core_gpr [32] = '{default: '0};
  int          wen_cnt = 0;
  logic [4:0]  last_wen_addr = 5'd0;

  // Reference state derived from command semantics.
  logic [31:0] ref_gpr [32] = '{default: '0};
  bit          ref_halted = 1'b0;

  dbg_ctrl #(.HALT_SETTLE(HS), .RESET_CYCLES(RC)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .halted     (halted),
    .jtag_halt  (jtag_halt),
    .jtag_reset (jtag_reset),
    .reg_wen    (reg_wen),
    .reg_addr   (reg_addr),
    .reg_w_data (reg_w_data),
    .reg_r_data (reg_r_data)
  );

  always #5 clk = ~clk;

  assign reg_r_data = core_gpr[reg_addr];

  always @(posedge clk) begin
    if (reg_wen) begin
      core_gpr[reg_addr] <= reg_w_data;
      wen_cnt            <= wen_cnt + 1;
      last_wen_addr      <= reg_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  endtask

  // Issue one command, wait for its response, hold it for 'hold' cycles, consume it.
  task automatic run_cmd(input logic [2:0] op, input logic [4:0] addr,
                         input logic [31:0] data, input int hold);
    int          exp_lat, exp_jr, exp_wen, cyc, jr_cnt, jh_bad, wen0;
    logic        exp_err;
    logic [31:0] exp_data;
    bit          got;
    exp_err  = 1'b0;
    exp_data = 32'd0;
    exp_lat  = 1;
    exp_jr   = 0;
    exp_wen  = 0;
    case (op)
      3'd1: begin
        exp_lat    = ref_halted ? 1 : int'(HS) + 1;
        ref_halted = 1'b1;
      end
      3'd2: ref_halted = 1'b0;
      3'd3: begin
        exp_lat = int'(RC) + 1;
        exp_jr  = int'(RC);
      end
      3'd4: if (ref_halted) begin
        exp_lat  = 2;
        exp_data = ref_gpr[addr];
      end else exp_err = 1'b1;
      3'd5: if (ref_halted) begin
        exp_lat       = 2;
        exp_wen       = 1;
        ref_gpr[addr] = data;
      end else exp_err = 1'b1;
      3'd6, 3'd7: exp_err = 1'b1;
      default: ;
    endcase

    @(negedge clk);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    wen0      = wen_cnt;
    @(posedge clk);
    #1 cmd_valid = 1'b0;

    cyc = 0; jr_cnt = 0; jh_bad = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (jtag_reset) jr_cnt++;
      if (jtag_halt !== ref_halted) jh_bad++;
      if (resp_valid) got = 1'b1;
    end
    if (!got) begin
      check("resp_timeout", 32'd0, 32'd1);
      summary();
    end

    check("latency",     32'(cyc), 32'(exp_lat));
    check("resp_err",    32'(resp_err), 32'(exp_err));
    check("resp_data",   resp_data, exp_data);
    check("halted",      32'(halted), 32'(ref_halted));
    check("jtag_halt",   32'(jh_bad), 32'd0);
    check("jtag_reset",  32'(jr_cnt), 32'(exp_jr));
    check("reg_wen_cnt", 32'(wen_cnt - wen0), 32'(exp_wen));
    if (exp_wen != 0) check("reg_wen_addr", 32'(last_wen_addr), 32'(addr));
    check("cmd_ready_busy", 32'(cmd_ready), 32'd0);

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_data",  resp_data, exp_data);
      check("bp_err",   32'(resp_err), 32'(exp_err));
      check("bp_ready", 32'(cmd_ready), 32'd0);
    end

    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_consumed", 32'(resp_valid), 32'd0);
    check("cmd_ready_back", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] r;
    logic [2:0] rop;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_cmd_ready",  32'(cmd_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data",  resp_data, 32'd0);
    check("rst_resp_err",   32'(resp_err), 32'd0);
    check("rst_halted",     32'(halted), 32'd0);
    check("rst_jtag_halt",  32'(jtag_halt), 32'd0);
    check("rst_jtag_reset", 32'(jtag_reset), 32'd0);
    check("rst_reg_port",   {reg_wen, reg_addr, 26'(reg_w_data != 0)}, 32'd0);
    rst = 1'b0;

    // Directed sequence.
    run_cmd(3'd0, 5'd0, 32'd0, 0);           // NOP
    run_cmd(3'd4, 5'd5, 32'd0, 0);           // REG_RD while running
    run_cmd(3'd5, 5'd5, 32'h1234_5678, 0);   // REG_WR while running
    run_cmd(3'd6, 5'd0, 32'd0, 0);           // illegal
    run_cmd(3'd7, 5'd0, 32'd0, 0);           // illegal
    run_cmd(3'd2, 5'd0, 32'd0, 0);           // RESUME while running
    run_cmd(3'd1, 5'd0, 32'd0, 0);           // HALT
    run_cmd(3'd1, 5'd0, 32'd0, 0);           // HALT while halted
    run_cmd(3'd5, 5'd5, 32'hDEAD_BEEF, 0);   // REG_WR
    run_cmd(3'd4, 5'd5, 32'd0, 0);           // REG_RD
    run_cmd(3'd3, 5'd0, 32'd0, 0);           // RESET while halted
    run_cmd(3'd4, 5'd5, 32'd0, 5);           // back-pressure
    run_cmd(3'd2, 5'd0, 32'd0, 2);           // RESUME

    // Random commands, biased towards register accesses.
    for (int k = 0; k < 60; k++) begin
      r   = 4'($urandom_range(0, 15));
      rop = (r < 4'd8) ? r[2:0] : ((r < 4'd12) ? 3'd4 : 3'd5);
      run_cmd(rop, 5'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, 3)));
    end

    // Reset asserted mid-RST aborts the pulse and drops the response.
    run_cmd(3'd1, 5'd0, 32'd0, 0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'd3;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_pulse", 32'(jtag_reset), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_jtag_reset", 32'(jtag_reset), 32'd0);
    check("abort_jtag_halt",  32'(jtag_halt), 32'd0);
    check("abort_halted",     32'(halted), 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_reg_wen",    32'(reg_wen), 32'd0);
    ref_halted = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_ready", 32'(cmd_ready), 32'd1);
      check("post_rst_stale", 32'(resp_valid), 32'd0);
    end
    run_cmd(3'd4, 5'd5, 32'd0, 0);           // not halted after reset

    summary();
  end

  initial begin
    #500000;
    check("global_timeout", 32'd0, 32'd1);
    summary();
  end

endmodule
